uart_rx: RTL and testbench

UART receiver. It is the downstream partner of the team's uart_tx and consumes the serial line that uart_tx drives. It uses the same shared 16x-oversampling baud_tick strobe to detect the start bit, sample 8 data bits LSB-first at bit centre, and check the stop bit. It presents each received byte with a one-cycle valid pulse, or flags a framing error.

---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, start-bit validation at half-bit,
// LSB-first data sampling at bit centre, stop-bit check with valid/frame_err pulses.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, frame_err_n;
    logic                 rx_meta, rx_s;

    // rx is asynchronous; both flops reset to the idle-high level
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        state_n     = state;
        tick_n      = tick_cnt;
        bit_n       = bit_cnt;
        shreg_n     = shreg;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
        if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        // a start bit that is gone by its centre is treated as a glitch
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_LAST) begin
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        tick_n  = '0;
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT)
                            state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == FULL_LAST) begin
                        // leave mid-stop-bit so a back-to-back start edge is not missed
                        if (rx_s) begin
                            data_n  = shreg;
                            valid_n = 1'b1;
                        end else begin
                            frame_err_n = 1'b1;
                        end
                        tick_n  = '0;
                        state_n = IDLE;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            busy      <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: per-tick line stimulus, frame-level reference model on the
// tick history, scoreboard queue popped by an independent output monitor.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] d;
    } exp_t;

    exp_t       expq[$];
    logic       line[$];     // rx level as seen on each baud tick since last reset
    int         pos = 0;     // first tick the receiver may still be hunting from
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] held = 8'h00;
    logic       prev_evt = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Frame rules on tick indices: low at k starts a hunt, centre at k+8,
    // data bit j at k+24+16j, stop at k+152, hunting resumes on the tick after.
    function automatic void scan();
        int k;
        logic [7:0] b;
        exp_t e;
        while (1) begin
            k = pos;
            while (k < line.size() && line[k] != 1'b0) k++;
            if (k + 8 >= line.size()) begin
                pos = k;
                return;
            end
            if (line[k+8]) begin
                pos = k + 9;
                continue;
            end
            if (k + 152 >= line.size()) begin
                pos = k;
                return;
            end
            for (int j = 0; j < 8; j++) b[j] = line[k + 24 + 16*j];
            e.err = !line[k+152];
            e.d   = b;
            expq.push_back(e);
            pos = k + 153;
        end
    endfunction

    // rx settles 3+ clk before the tick so the synchronized value is what the tick sees
    task automatic send_tick(input logic v);
        rx = v;
        repeat (3) @(negedge clk);
        line.push_back(v);
        scan();
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    task automatic send_bits(input logic v, input int n);
        for (int i = 0; i < n; i++) send_tick(v);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
        send_bits(1'b0, 16);
        for (int j = 0; j < 8; j++) send_bits(b[j], 16);
        send_bits(stop, 16);
        send_bits(1'b1, gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        baud_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        line.delete();
        pos  = 0;
        held = 8'h00;
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_frame_err", frame_err, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (prev_evt) check("busy_after_pulse", busy, 0);
        prev_evt = valid | frame_err;
        if (valid || frame_err) begin
            check("pulse_exclusive", valid & frame_err, 0);
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got valid=%b frame_err=%b data=%h, want no pulse",
                         valid, frame_err, data);
            end else begin
                e = expq.pop_front();
                check("pulse_kind_frame_err", frame_err, e.err);
                check("busy_at_pulse", busy, 1);
                if (!e.err) held = e.d;
                check("data", data, held);
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int kind;
        logic [7:0] b;
        do_reset();
        send_bits(1'b1, 20);

        // nominal byte
        send_frame(8'hA5, 1'b1, 20);
        check("data_after_a5", data, 8'hA5);

        // back-to-back, no idle gap
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 20);

        // start glitch, then a good byte
        send_bits(1'b0, 4);
        send_bits(1'b1, 30);
        check("data_after_glitch", data, 8'hFF);
        send_frame(8'h3C, 1'b1, 20);

        // framing error keeps old data
        send_frame(8'h11, 1'b1, 10);
        send_frame(8'h3C, 1'b0, 30);
        check("data_after_ferr", data, 8'h11);

        // reset mid-frame after three data bits of 0x96
        send_bits(1'b0, 16);
        send_bits(1'b0, 16);
        send_bits(1'b1, 16);
        send_bits(1'b1, 16);
        do_reset();
        send_bits(1'b1, 320);
        send_frame(8'h5A, 1'b1, 20);

        // break: line low for 25 bit times
        send_bits(1'b0, 400);
        send_bits(1'b1, 200);

        // randomized frames, glitches, bad stop bits and gaps
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 9);
            b = 8'($urandom);
            if (kind == 0) begin
                send_bits(1'b0, $urandom_range(1, 7));
                send_bits(1'b1, $urandom_range(9, 20));
            end else if (kind == 1) begin
                send_frame(b, 1'b0, $urandom_range(0, 20));
            end else begin
                send_frame(b, 1'b1, $urandom_range(0, 20));
            end
        end

        send_bits(1'b1, 200);
        check("pending_expected", expq.size(), 0);
        check("data_hold_end", data, held);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
